// File: rtl/oldland_fetch.sv
// Instruction fetch stage: walks the pc over a single-outstanding instruction bus,
// buffers one word while decode stalls, and handles branch/exception redirects.
module oldland_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h10000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic        exception_start,
  input  logic [31:0] vector_base,
  output logic [29:0] i_addr,
  output logic        i_access,
  input  logic        i_ack,
  input  logic [31:0] i_data,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4,
  output logic        i_fetched,
  output logic        stopped,
  output logic [1:0]  fetch_state
);

  // Handshakes: i_access with i_addr stays asserted and stable until the bus
  // returns i_ack, whose i_data is valid for that cycle only; decode accepts
  // the presented instr on any cycle where stall is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SKID = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] redirect_pc;
  logic        discard;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        ack_live;
  logic        take_word;
  logic        deliver_now;
  logic        to_skid;
  logic        skid_out;

  assign pc_inc          = pc + 32'd4;
  assign redirect        = exception_start | branch_taken;
  assign redirect_target = (exception_start ? vector_base : branch_pc) & 32'hFFFF_FFFC;
  assign ack_live        = (state == REQ) && i_ack;
  assign take_word       = ack_live && !discard && !redirect;
  assign deliver_now     = take_word && !stall;
  assign to_skid         = take_word && stall;
  assign skid_out        = (state == SKID) && !stall && !redirect;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (run && !stall && !redirect) state_next = REQ;
      end
      REQ: begin
        if (ack_live) begin
          if (redirect || discard || !stall) state_next = run ? REQ : IDLE;
          else                               state_next = SKID;
        end
      end
      SKID: begin
        if (redirect || !stall) state_next = run ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    i_access    = (state == REQ);
    i_addr      = pc[31:2];
    fetch_state = state;
  end

  // A redirect that lands mid-access keeps the bus address stable and parks
  // the target until the orphaned word returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      redirect_pc <= 32'd0;
      discard     <= 1'b0;
      instr       <= NOP_INSTR;
      pc_plus_4   <= 32'd0;
      i_fetched   <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc4    <= 32'd0;
      stopped     <= 1'b0;
    end else begin
      stopped <= !run && (state_next != REQ);

      if (redirect) begin
        if ((state == REQ) && !i_ack) begin
          discard     <= 1'b1;
          redirect_pc <= redirect_target;
        end else begin
          pc      <= redirect_target;
          discard <= 1'b0;
        end
      end else if (ack_live) begin
        if (discard) begin
          pc      <= redirect_pc;
          discard <= 1'b0;
        end else begin
          pc <= pc_inc;
        end
      end

      if (redirect) begin
        instr     <= NOP_INSTR;
        i_fetched <= 1'b0;
      end else if (deliver_now) begin
        instr     <= i_data;
        pc_plus_4 <= pc_inc;
        i_fetched <= 1'b1;
      end else if (skid_out) begin
        instr     <= skid_instr;
        pc_plus_4 <= skid_pc4;
        i_fetched <= 1'b1;
      end else if (!stall) begin
        instr     <= NOP_INSTR;
        i_fetched <= 1'b0;
      end

      if (redirect) begin
        skid_instr <= NOP_INSTR;
        skid_pc4   <= 32'd0;
      end else if (to_skid) begin
        skid_instr <= i_data;
        skid_pc4   <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_oldland_fetch.sv
// Bench for oldland_fetch: directed scenarios plus a randomized run checked
// against an address-stream scoreboard.
module tb_oldland_fetch;

  localparam logic [31:0] RESET_PC = 32'h10000000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        run;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        exception_start;
  logic [31:0] vector_base;
  logic [29:0] i_addr;
  logic        i_access;
  logic        i_ack;
  logic [31:0] i_data;
  logic [31:0] instr;
  logic [31:0] pc_plus_4;
  logic        i_fetched;
  logic        stopped;
  logic [1:0]  fetch_state;

  int n_checks = 0;
  int n_fail   = 0;
  int bus_lat  = 0;
  int bus_cnt  = 0;
  bit bus_auto = 1'b1;
  bit bus_rand = 1'b0;
  logic [31:0] exp_q[$];

  oldland_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .run(run), .stall(stall),
    .branch_taken(branch_taken), .branch_pc(branch_pc),
    .exception_start(exception_start), .vector_base(vector_base),
    .i_addr(i_addr), .i_access(i_access), .i_ack(i_ack), .i_data(i_data),
    .instr(instr), .pc_plus_4(pc_plus_4), .i_fetched(i_fetched),
    .stopped(stopped), .fetch_state(fetch_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A3C96E1;
  endfunction

  // Advance one clock, then play the memory for the new cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus_auto) begin
      if (i_access === 1'b1) begin
        if (bus_cnt >= bus_lat) begin
          i_ack   = 1'b1;
          i_data  = mem_word(i_addr);
          bus_cnt = 0;
          if (bus_rand) bus_lat = $urandom_range(0, 3);
        end else begin
          i_ack   = 1'b0;
          i_data  = $urandom;
          bus_cnt++;
        end
      end else begin
        i_ack   = 1'b0;
        bus_cnt = 0;
      end
    end
  endtask

  task automatic do_reset(input logic r);
    rst = 1'b1; run = r; stall = 1'b0;
    branch_taken = 1'b0; exception_start = 1'b0;
    branch_pc = 32'd0; vector_base = 32'd0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; exception_start = 1'b0;
    branch_pc = 32'd0; vector_base = 32'd0; i_ack = 1'b0; i_data = 32'd0;
    cycle();
    n_checks++;
    if ({i_access, i_fetched, stopped} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {i_access, i_fetched, stopped});
    end
    n_checks++;
    if (instr !== NOP) begin
      n_fail++; $display("FAIL reset_instr: got %h required %h", instr, NOP);
    end
    n_checks++;
    if (pc_plus_4 !== 32'd0) begin
      n_fail++; $display("FAIL reset_pc4: got %h required 0", pc_plus_4);
    end
    n_checks++;
    if (i_addr !== RESET_PC[31:2]) begin
      n_fail++; $display("FAIL reset_addr: got %h required %h", i_addr, RESET_PC[31:2]);
    end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    bus_lat = 1; bus_rand = 1'b0;
    do_reset(1'b1);
    n_checks++;
    if (i_access !== 1'b0) begin
      n_fail++; $display("FAIL first_idle_cycle: got i_access=%b required 0", i_access);
    end
    cycle();
    n_checks++;
    if ({i_access, i_addr, i_fetched} !== {1'b1, 30'h04000000, 1'b0}) begin
      n_fail++; $display("FAIL first_request: got acc=%b addr=%h fet=%b required 1 04000000 0", i_access, i_addr, i_fetched);
    end
    cycle();
    cycle();
    n_checks++;
    if ({instr, pc_plus_4, i_fetched} !== {mem_word(30'h04000000), 32'h10000004, 1'b1}) begin
      n_fail++; $display("FAIL first_word: got %h %h %b required %h 10000004 1", instr, pc_plus_4, i_fetched, mem_word(30'h04000000));
    end
    n_checks++;
    if ({i_access, i_addr} !== {1'b1, 30'h04000001}) begin
      n_fail++; $display("FAIL first_next_addr: got %b %h required 1 04000001", i_access, i_addr);
    end
  endtask

  task automatic test_stall_skid();
    logic [31:0] w0;
    logic [1:0]  fs_req;
    logic [1:0]  fs_skid;
    w0 = mem_word(30'h04000000);
    bus_lat = 1;
    do_reset(1'b1);
    cycle(); cycle(); cycle();
    fs_req = fetch_state;
    stall = 1'b1;
    cycle();
    n_checks++;
    if ({instr, pc_plus_4, i_fetched} !== {w0, 32'h10000004, 1'b1}) begin
      n_fail++; $display("FAIL stall_ack_hold: got %h %h %b required %h 10000004 1", instr, pc_plus_4, i_fetched, w0);
    end
    cycle();
    fs_skid = fetch_state;
    n_checks++;
    if (fs_skid === fs_req) begin
      n_fail++; $display("FAIL skid_state_distinct: got %h required not %h", fs_skid, fs_req);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({i_access, instr, pc_plus_4, i_fetched, fetch_state} !== {1'b0, w0, 32'h10000004, 1'b1, fs_skid}) begin
        n_fail++; $display("FAIL skid_hold[%0d]: got %b %h %h %b %h required 0 %h 10000004 1 %h", k, i_access, instr, pc_plus_4, i_fetched, fetch_state, w0, fs_skid);
      end
      if (k == 2) stall = 1'b0;
      cycle();
    end
    n_checks++;
    if ({instr, pc_plus_4, i_fetched} !== {mem_word(30'h04000001), 32'h10000008, 1'b1}) begin
      n_fail++; $display("FAIL skid_release: got %h %h %b required %h 10000008 1", instr, pc_plus_4, i_fetched, mem_word(30'h04000001));
    end
    n_checks++;
    if ({i_access, i_addr} !== {1'b1, 30'h04000002}) begin
      n_fail++; $display("FAIL skid_resume_addr: got %b %h required 1 04000002", i_access, i_addr);
    end
    cycle();
    n_checks++;
    if ({instr, i_fetched} !== {NOP, 1'b0}) begin
      n_fail++; $display("FAIL bubble_nop: got %h %b required %h 0", instr, i_fetched, NOP);
    end
  endtask

  task automatic test_branch_discard();
    bus_lat = 2;
    do_reset(1'b1);
    cycle();
    branch_taken = 1'b1; branch_pc = 32'h00002000;
    cycle();
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({i_access, i_addr, i_fetched} !== {1'b1, 30'h04000000, 1'b0}) begin
        n_fail++; $display("FAIL discard_hold[%0d]: got %b %h %b required 1 04000000 0", k, i_access, i_addr, i_fetched);
      end
      cycle();
    end
    n_checks++;
    if ({i_access, i_addr, i_fetched} !== {1'b1, 30'h00000800, 1'b0}) begin
      n_fail++; $display("FAIL branch_target_addr: got %b %h %b required 1 00000800 0", i_access, i_addr, i_fetched);
    end
    cycle();
    cycle();
    n_checks++;
    if (i_fetched !== 1'b0) begin
      n_fail++; $display("FAIL branch_wait_fetched: got %b required 0", i_fetched);
    end
    cycle();
    n_checks++;
    if ({instr, pc_plus_4, i_fetched} !== {mem_word(30'h800), 32'h00002004, 1'b1}) begin
      n_fail++; $display("FAIL branch_word: got %h %h %b required %h 00002004 1", instr, pc_plus_4, i_fetched, mem_word(30'h800));
    end
  endtask

  task automatic test_priority();
    bus_lat = 0;
    do_reset(1'b1);
    cycle();
    exception_start = 1'b1; branch_taken = 1'b1;
    vector_base = 32'h00000103; branch_pc = 32'h00003000;
    cycle();
    exception_start = 1'b0; branch_taken = 1'b0;
    n_checks++;
    if ({i_access, i_addr, i_fetched} !== {1'b1, 30'h00000040, 1'b0}) begin
      n_fail++; $display("FAIL exc_priority_addr: got %b %h %b required 1 00000040 0", i_access, i_addr, i_fetched);
    end
    cycle();
    n_checks++;
    if ({instr, pc_plus_4, i_fetched} !== {mem_word(30'h40), 32'h00000104, 1'b1}) begin
      n_fail++; $display("FAIL exc_vector_word: got %h %h %b required %h 00000104 1", instr, pc_plus_4, i_fetched, mem_word(30'h40));
    end
  endtask

  task automatic test_wrap();
    bus_lat = 0;
    do_reset(1'b1);
    branch_taken = 1'b1; branch_pc = 32'hFFFFFFFE;
    cycle();
    branch_taken = 1'b0;
    n_checks++;
    if (i_access !== 1'b0) begin
      n_fail++; $display("FAIL idle_redirect_no_req: got %b required 0", i_access);
    end
    cycle();
    n_checks++;
    if ({i_access, i_addr} !== {1'b1, 30'h3FFFFFFF}) begin
      n_fail++; $display("FAIL wrap_req_addr: got %b %h required 1 3fffffff", i_access, i_addr);
    end
    cycle();
    n_checks++;
    if ({instr, pc_plus_4, i_fetched, i_addr} !== {mem_word(30'h3FFFFFFF), 32'h0, 1'b1, 30'h0}) begin
      n_fail++; $display("FAIL wrap_pc: got %h %h %b %h required %h 0 1 0", instr, pc_plus_4, i_fetched, i_addr, mem_word(30'h3FFFFFFF));
    end
  endtask

  task automatic test_run_stop();
    bus_lat = 2;
    do_reset(1'b1);
    cycle();
    run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_checks++;
      if ({i_access, stopped} !== 2'b10) begin
        n_fail++; $display("FAIL drain_pending[%0d]: got %b required 10", k, {i_access, stopped});
      end
    end
    cycle();
    n_checks++;
    if ({stopped, i_access, instr, i_fetched} !== {1'b1, 1'b0, mem_word(30'h04000000), 1'b1}) begin
      n_fail++; $display("FAIL drain_done: got %b %b %h %b required 1 0 %h 1", stopped, i_access, instr, i_fetched, mem_word(30'h04000000));
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++;
      if ({i_access, stopped} !== 2'b01) begin
        n_fail++; $display("FAIL halted[%0d]: got %b required 01", k, {i_access, stopped});
      end
    end
    run = 1'b1;
    cycle();
    n_checks++;
    if ({stopped, i_access, i_addr} !== {1'b0, 1'b1, 30'h04000001}) begin
      n_fail++; $display("FAIL restart: got %b %b %h required 0 1 04000001", stopped, i_access, i_addr);
    end
  endtask

  task automatic test_reset_mid_access();
    bus_lat = 3;
    do_reset(1'b1);
    cycle();
    rst = 1'b1;
    cycle();
    n_checks++;
    if (i_access !== 1'b0) begin
      n_fail++; $display("FAIL rst_drops_access: got %b required 0", i_access);
    end
    rst = 1'b0; bus_auto = 1'b0; i_ack = 1'b1; i_data = 32'hBAD0BAD0;
    cycle();
    i_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({i_access, i_addr, i_fetched, instr} !== {1'b1, 30'h04000000, 1'b0, NOP}) begin
        n_fail++; $display("FAIL stale_ack_ignored[%0d]: got %b %h %b %h required 1 04000000 0 %h", k, i_access, i_addr, i_fetched, instr, NOP);
      end
      cycle();
    end
    bus_auto = 1'b1;
  endtask

  task automatic test_stall_redirect();
    bus_lat = 1;
    do_reset(1'b1);
    cycle(); cycle(); cycle();
    stall = 1'b1; branch_taken = 1'b1; branch_pc = 32'h00004000;
    cycle();
    branch_taken = 1'b0;
    n_checks++;
    if ({instr, i_fetched} !== {NOP, 1'b0}) begin
      n_fail++; $display("FAIL redirect_in_stall: got %h %b required %h 0", instr, i_fetched, NOP);
    end
    cycle();
    n_checks++;
    if ({i_access, i_addr} !== {1'b1, 30'h00001000}) begin
      n_fail++; $display("FAIL redirect_in_stall_addr: got %b %h required 1 00001000", i_access, i_addr);
    end
    stall = 1'b0;
  endtask

  task automatic refill_q();
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  task automatic test_random();
    logic        prev_hold;
    logic        prev_pending;
    logic [29:0] prev_addr;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc4;
    logic        prev_fet;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    int          r;
    int          consumed;
    bus_rand = 1'b1; bus_lat = 1;
    do_reset(1'b1);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    refill_q();
    prev_hold = 1'b0; prev_pending = 1'b0; consumed = 0;
    prev_addr = '0; prev_instr = '0; prev_pc4 = '0; prev_fet = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_hold) begin
        n_checks++;
        if ({instr, pc_plus_4, i_fetched} !== {prev_instr, prev_pc4, prev_fet}) begin
          n_fail++; $display("FAIL rand_stall_hold c=%0d: got %h %h %b required %h %h %b", c, instr, pc_plus_4, i_fetched, prev_instr, prev_pc4, prev_fet);
        end
      end
      if (prev_pending) begin
        n_checks++;
        if ({i_access, i_addr} !== {1'b1, prev_addr}) begin
          n_fail++; $display("FAIL rand_bus_stable c=%0d: got %b %h required 1 %h", c, i_access, i_addr, prev_addr);
        end
      end
      stall = ($urandom_range(0, 99) < 30);
      r = $urandom_range(0, 99);
      exception_start = (r < 3);
      branch_taken = (r < 2) || (r >= 3 && r < 8);
      branch_pc   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
      vector_base = $urandom;
      if (exception_start || branch_taken) begin
        tgt = (exception_start ? vector_base : branch_pc) & 32'hFFFFFFFC;
        exp_q.delete();
        exp_q.push_back(tgt);
        refill_q();
      end else if (i_fetched === 1'b1 && !stall) begin
        exp_pc = exp_q.pop_front();
        refill_q();
        consumed++;
        n_checks++;
        if ({instr, pc_plus_4} !== {mem_word(exp_pc[31:2]), exp_pc + 32'd4}) begin
          n_fail++; $display("FAIL rand_stream c=%0d: got %h %h required %h %h", c, instr, pc_plus_4, mem_word(exp_pc[31:2]), exp_pc + 32'd4);
        end
      end
      prev_hold    = stall && !(exception_start || branch_taken);
      prev_pending = i_access && !i_ack;
      prev_addr    = i_addr;
      prev_instr   = instr;
      prev_pc4     = pc_plus_4;
      prev_fet     = i_fetched;
      cycle();
    end
    exception_start = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    bus_rand = 1'b0;
    n_checks++;
    if (consumed < 200) begin
      n_fail++; $display("FAIL rand_progress: got %0d consumed required at least 200", consumed);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; exception_start = 1'b0;
    branch_pc = 32'd0; vector_base = 32'd0;
    i_ack = 1'b0; i_data = 32'd0;
    test_reset();
    test_first_fetch();
    test_stall_skid();
    test_branch_discard();
    test_priority();
    test_wrap();
    test_run_stop();
    test_reset_mid_access();
    test_stall_redirect();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oldland_fetch.md
OLDLAND_FETCH -- requirements
Module: oldland_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h10000000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000000, legal side-effect-free encoding presented to decode during bubbles.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 run  in  1  high permits new fetches; low drains and halts (debug).
REQ-006 stall  in  1  decode not consuming current instr; hold outputs.
REQ-007 branch_taken  in  1  redirect to branch_pc.
REQ-008 branch_pc  in  32  branch target, bits [1:0] ignored.
REQ-009 exception_start  in  1  redirect to vector_base.
REQ-010 vector_base  in  32  exception target, bits [1:0] ignored.
REQ-011 i_addr  out  30  instruction bus word address.
REQ-012 i_access  out  1  bus request; held with stable i_addr until i_ack.
REQ-013 i_ack  in  1  bus completion; i_data valid this cycle only.
REQ-014 i_data  in  32  fetched word.
REQ-015 instr  out  32  instruction to decode (registered).
REQ-016 pc_plus_4  out  32  address of instr plus 4 (registered).
REQ-017 i_fetched  out  1  instr is a real fetched word, not a bubble.
REQ-018 stopped  out  1  run low and no access outstanding.

Function
REQ-019 SHALL keep fetch pc register, 32 bits, bits [1:0] always zero; i_addr = pc[31:2].
REQ-020 SHALL implement states IDLE (no access), REQ (i_access=1), SKID (word buffered, stall high).
REQ-021 IDLE->REQ next cycle when run=1, stall=0, no redirect this cycle.
REQ-022 REQ, i_ack, stall=0, no discard: instr<=i_data, pc_plus_4<=pc+4, i_fetched<=1, pc<=pc+4; stay REQ if run=1 (back-to-back, one fetch per ack) else IDLE.
REQ-023 REQ, i_ack, stall=1: word and pc+4 into skid buffer, pc<=pc+4, go SKID; outputs unchanged.
REQ-024 SKID, stall falls: skid word/pc+4 -> instr/pc_plus_4, i_fetched<=1, then REQ (run=1) or IDLE.
REQ-025 SHALL not assert i_access in SKID or IDLE; latency i_ack -> i_fetched exactly 1 cycle when unstalled.
REQ-026 Outputs SHALL hold all values while stall=1, except on redirect.
REQ-027 REQ with no instr consumed and stall=0, no i_ack: i_fetched<=0, instr<=NOP_INSTR.
REQ-028 Redirect (exception_start or branch_taken): pc<=target&~3, instr<=NOP_INSTR, i_fetched<=0, skid cleared, regardless of stall.
REQ-029 exception_start SHALL take priority over branch_taken when simultaneous.
REQ-030 Redirect while access pending without i_ack: set discard flag; i_access/i_addr held; returned word dropped; new fetch from target issued cycle after ack.
REQ-031 Redirect in same cycle as i_ack: word dropped; REQ restarts at target next cycle.
REQ-032 run falling during REQ: pending access completes normally, then IDLE; stopped=1 from cycle after ack.
REQ-033 pc arithmetic SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 = 0).

Reset
REQ-034 On rst: pc=RESET_PC, state=IDLE, i_access=0, instr=NOP_INSTR, pc_plus_4=0, i_fetched=0, discard=0, skid empty, stopped=0.
REQ-035 rst mid-access SHALL drop i_access same edge; any later i_ack for it ignored.
REQ-036 First i_access SHALL assert the second cycle after rst deasserts when run=1.

Verification
REQ-037 Reset, run=1, bus acks 1 cycle after request -> i_addr=0x04000000, then instr=i_data, pc_plus_4=0x10000004, i_fetched=1.
REQ-038 Ack while stall=1, then stall low 3 cycles later -> outputs unchanged in stall, skid word appears cycle after stall falls, no i_access during SKID.
REQ-039 branch_taken to 0x2000 with access pending 2 more cycles -> pending word discarded, next i_addr=0x800, i_fetched=0 until its ack.
REQ-040 exception_start and branch_taken same cycle, vector_base=0x100 -> next fetch i_addr=0x40.
REQ-041 pc=0xFFFFFFFC fetched -> pc_plus_4=0, next i_addr=0.
REQ-042 run low mid-access -> access completes, stopped=1 next cycle, no further i_access until run=1.
